// File: rtl/stopwatch_pkg.sv
// Shared stopwatch constants, BCD digit type and control-priority decode.
package stopwatch_pkg;

    localparam int unsigned DIGIT_W      = 4;
    localparam int unsigned ONES_MAX     = 9;
    localparam int unsigned TENS_MAX     = 5;
    localparam int unsigned DEF_TICK_DIV = 500_000;

    typedef logic [DIGIT_W-1:0] bcd_t;

    typedef enum logic [1:0] {
        CtlClear,
        CtlPrepare,
        CtlRun,
        CtlHold
    } ctl_e;

    // Highest-priority active control wins; rst is handled separately by each register.
    function automatic ctl_e decode_ctl(logic clear, logic prepare_start, logic running);
        if (clear)         return CtlClear;
        if (prepare_start) return CtlPrepare;
        if (running)       return CtlRun;
        return CtlHold;
    endfunction

endpackage

// File: rtl/stopwatch_counter_if.sv
// Control levels in, registered BCD time, tick and overflow out.
interface stopwatch_counter_if;
    import stopwatch_pkg::*;

    logic clear;
    logic prepare_start;
    logic running;
    bcd_t csec_ones;
    bcd_t csec_tens;
    bcd_t sec_ones;
    bcd_t sec_tens;
    bcd_t min_ones;
    bcd_t min_tens;
    logic tick;
    logic overflow;

    modport master (
        output clear, prepare_start, running,
        input  csec_ones, csec_tens, sec_ones, sec_tens, min_ones, min_tens, tick, overflow
    );

    modport slave (
        input  clear, prepare_start, running,
        output csec_ones, csec_tens, sec_ones, sec_tens, min_ones, min_tens, tick, overflow
    );

endinterface

// File: rtl/bcd_digit_counter.sv
// One registered BCD digit counting 0..MAX; carry is high when an increment wraps it.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned MAX = ONES_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output bcd_t digit,
    output logic carry
);

    localparam bcd_t LAST = bcd_t'(MAX);

    bcd_t digit_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            digit_q <= '0;
        end else if (inc) begin
            digit_q <= (digit_q == LAST) ? '0 : digit_q + 1'b1;
        end
    end

    assign digit = digit_q;
    assign carry = inc && (digit_q == LAST);

endmodule

// File: rtl/stopwatch_counter.sv
// mm:ss.cc stopwatch: prescaler divides clk down to 10 ms steps feeding a six-digit BCD chain.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
    input  logic         clk,
    input  logic         rst,
    stopwatch_counter_if.slave sw
);

    localparam int unsigned     PRESC_W    = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    logic [PRESC_W-1:0] presc_q;
    logic               tick_q;
    logic               overflow_q;
    ctl_e               ctl;
    logic               step;
    logic [5:0]         carry;

    assign ctl  = decode_ctl(sw.clear, sw.prepare_start, sw.running);
    assign step = (ctl == CtlRun) && (presc_q == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= '0;
            tick_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            unique case (ctl)
                CtlClear: begin
                    presc_q    <= '0;
                    tick_q     <= 1'b0;
                    overflow_q <= 1'b0;
                end
                CtlPrepare: begin
                    presc_q <= '0;
                    tick_q  <= 1'b0;
                end
                CtlRun: begin
                    presc_q <= step ? '0 : presc_q + 1'b1;
                    tick_q  <= step;
                    // The whole chain carrying out means 59:59.99 just wrapped to zero.
                    if (carry[5]) overflow_q <= 1'b1;
                end
                CtlHold: begin
                    tick_q <= 1'b0;
                end
                default: begin
                    tick_q <= 1'b0;
                end
            endcase
        end
    end

    bcd_digit_counter #(.MAX(ONES_MAX)) u_csec_ones (
        .clk   (clk),
        .rst   (rst),
        .clr   (sw.clear),
        .inc   (step),
        .digit (sw.csec_ones),
        .carry (carry[0])
    );

    bcd_digit_counter #(.MAX(ONES_MAX)) u_csec_tens (
        .clk   (clk),
        .rst   (rst),
        .clr   (sw.clear),
        .inc   (carry[0]),
        .digit (sw.csec_tens),
        .carry (carry[1])
    );

    bcd_digit_counter #(.MAX(ONES_MAX)) u_sec_ones (
        .clk   (clk),
        .rst   (rst),
        .clr   (sw.clear),
        .inc   (carry[1]),
        .digit (sw.sec_ones),
        .carry (carry[2])
    );

    bcd_digit_counter #(.MAX(TENS_MAX)) u_sec_tens (
        .clk   (clk),
        .rst   (rst),
        .clr   (sw.clear),
        .inc   (carry[2]),
        .digit (sw.sec_tens),
        .carry (carry[3])
    );

    bcd_digit_counter #(.MAX(ONES_MAX)) u_min_ones (
        .clk   (clk),
        .rst   (rst),
        .clr   (sw.clear),
        .inc   (carry[3]),
        .digit (sw.min_ones),
        .carry (carry[4])
    );

    bcd_digit_counter #(.MAX(TENS_MAX)) u_min_tens (
        .clk   (clk),
        .rst   (rst),
        .clr   (sw.clear),
        .inc   (carry[4]),
        .digit (sw.min_tens),
        .carry (carry[5])
    );

    assign sw.tick     = tick_q;
    assign sw.overflow = overflow_q;

endmodule

// File: doc/stopwatch_counter.md
STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 Parameter TICK_DIV, default 500_000, clk cycles per 10 ms time step (50 MHz clk); legal range 2..2^24.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 clear  input  1  level; zero the elapsed time (from upstream button handler).
REQ-005 prepare_start  input  1  level; realign the prescaler before a run starts.
REQ-006 running  input  1  level; advance time while high.
REQ-007 csec_ones, csec_tens  output  4 each  BCD hundredths-of-second digits.
REQ-008 sec_ones, sec_tens  output  4 each  BCD seconds digits (tens 0..5).
REQ-009 min_ones, min_tens  output  4 each  BCD minutes digits (tens 0..5).
REQ-010 tick  output  1  one-cycle pulse, high in the cycle after the digits advance.
REQ-011 overflow  output  1  sticky flag, set when time wraps past 59:59.99.

Function
REQ-012 All outputs shall be registered; no combinational path from inputs to outputs.
REQ-013 Control priority each cycle shall be rst > clear > prepare_start > running > hold.
REQ-014 clear high: all digits 0, prescaler 0, overflow 0, tick 0 on the next edge.
REQ-015 prepare_start high (clear low): prescaler 0, digits and overflow held, tick 0.
REQ-016 running high (clear, prepare_start low): prescaler increments by 1 per cycle.
REQ-017 When running and prescaler == TICK_DIV-1, prescaler shall wrap to 0 and digits advance by 0.01 s on that same edge.
REQ-018 First advance after prepare_start deasserts and running asserts shall occur exactly TICK_DIV running cycles later.
REQ-019 Digit carry chain: csec_ones 9->0 carries into csec_tens; csec_tens 9->0 into sec_ones; sec_ones 9->0 into sec_tens; sec_tens 5->0 into min_ones; min_ones 9->0 into min_tens; min_tens 5->0 wraps.
REQ-020 Carries shall ripple within one edge; no intermediate digit values shall be visible at outputs.
REQ-021 Advance from 59:59.99 shall produce 00:00.00 and set overflow; overflow stays set until clear or rst.
REQ-022 tick shall be high for exactly one cycle following each digit advance, including the wrap advance.
REQ-023 All inputs low (stopped): digits, prescaler, overflow held; resumed running continues from the held prescaler value (pause preserves fractional step).
REQ-024 clear asserted mid-run shall override running in the same cycle; no advance occurs on that edge.
REQ-025 Digits shall never hold a non-BCD value or a tens value above 5 for seconds/minutes.

Reset
REQ-026 rst high on an edge shall set all digits 0, prescaler 0, tick 0, overflow 0, regardless of other inputs.
REQ-027 Reset mid-run shall take effect on the next edge with no further advance; counting resumes only per REQ-016 after rst deasserts.

Structure
REQ-028 Shared package/header stopwatch_pkg shall hold BCD digit width (4), digit maxima (9, 5), and default TICK_DIV.
REQ-029 Prescaler width shall be derived from TICK_DIV via clog2, not hard-coded.
REQ-030 One sub-module bcd_digit_counter (parameter MAX, inputs clk/rst/clr/inc, outputs digit/carry) shall be instantiated six times; prescaler and control live in the top.

Verification (bench TICK_DIV=4)
REQ-031 rst 2 cycles, then running 40 cycles -> 10 tick pulses, time 00:00.10, overflow 0.
REQ-032 running 6 cycles, all low 10 cycles, running 2 cycles -> exactly 2 ticks, time 00:00.02 (pause preserves prescaler phase).
REQ-033 Preload via running to 00:59.99, one more step -> 01:00.00 in a single edge, tick pulse once.
REQ-034 Run to 59:59.99, one more step -> 00:00.00, overflow 1; then clear 1 cycle -> overflow 0, digits 0.
REQ-035 running with clear and prepare_start both high -> digits and prescaler 0, no tick; prepare_start+running only -> digits held, no tick.
REQ-036 rst asserted on the cycle prescaler==3 while running -> no advance, all outputs 0 after that edge.
